gol_engine: RTL and testbench

- Game-of-Life generation engine, upstream of the display path.
- Reads the current generation from the display-visible frame bank and computes the next generation. Writes it into the other bank, then flips the bank select used by the pixel feeder.
- Cells are 4-bit ages (0 = dead). The age feeds the colour LUT directly as a colour index.
- Uses its own port of the dual-port frame memory and never contends with display reads.

---
 rtl/gol_engine.sv | 177 +++++++++++++++++
 tb/tb_gol_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gol_engine.sv
// Game-of-Life generation engine: reads the displayed bank, writes the next
// generation of 4-bit cell ages into the other bank, then flips the banks.
module gol_engine #(
    parameter int COLS_WORDS = 8,
    parameter int ROWS       = 64,
    parameter int MAX_AGE    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        disp_bank,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count,
    output logic        mem_rd_en,
    output logic        mem_rd_bank,
    output logic [8:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic        mem_wr_bank,
    output logic [8:0]  mem_wr_addr,
    output logic [31:0] mem_wr_data
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW = (COLS_WORDS > 1) ? $clog2(COLS_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, READ, COMPUTE, WRITE, SWAP} state_t;
    state_t state;

    logic [RW-1:0] row, nxt_row;
    logic [WW-1:0] word, nxt_word;
    logic [1:0]    dr, dw, step_dr, step_dw, prev_dr, prev_dw;
    logic          last_word, last_row;
    logic [31:0]   win [3][3];
    logic [31:0]   cw [3][3];
    logic [9:0]    alive_row [3];
    logic [31:0]   next_data;

    assign mem_rd_bank = disp_bank;
    assign mem_wr_bank = ~disp_bank;

    // Word address of window slot (odr, odw) around (r, w), wrapping toroidally.
    function automatic logic [8:0] rd_address(input logic [RW-1:0] r, input logic [WW-1:0] w,
                                              input logic [1:0] odr, input logic [1:0] odw);
        logic [RW-1:0] ry;
        logic [WW-1:0] wx;
        if (odr == 2'd0)      ry = (r == '0) ? RW'(ROWS - 1) : r - RW'(1);
        else if (odr == 2'd2) ry = (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
        else                  ry = r;
        if (odw == 2'd0)      wx = (w == '0) ? WW'(COLS_WORDS - 1) : w - WW'(1);
        else if (odw == 2'd2) wx = (w == WW'(COLS_WORDS - 1)) ? '0 : w + WW'(1);
        else                  wx = w;
        return 9'(int'(ry) * COLS_WORDS + int'(wx));
    endfunction

    // t/b are the three cells above/below; m holds the left and right neighbours.
    function automatic logic [3:0] cell_next(input logic [3:0] age, input logic [2:0] t,
                                             input logic [1:0] m, input logic [2:0] b);
        logic [3:0] cnt;
        cnt = 4'(t[0]) + 4'(t[1]) + 4'(t[2]) + 4'(m[0]) + 4'(m[1])
            + 4'(b[0]) + 4'(b[1]) + 4'(b[2]);
        if (age != 4'd0 && (cnt == 4'd2 || cnt == 4'd3))
            return (age >= 4'(MAX_AGE)) ? 4'(MAX_AGE) : age + 4'd1;
        else if (age == 4'd0 && cnt == 4'd3)
            return 4'd1;
        else
            return 4'd0;
    endfunction

    always_comb begin
        step_dw   = (dw == 2'd2) ? 2'd0 : dw + 2'd1;
        step_dr   = (dw == 2'd2) ? dr + 2'd1 : dr;
        prev_dw   = (dw == 2'd0) ? 2'd2 : dw - 2'd1;
        prev_dr   = (dw == 2'd0) ? dr - 2'd1 : dr;
        last_word = (word == WW'(COLS_WORDS - 1));
        last_row  = (row == RW'(ROWS - 1));
        nxt_word  = last_word ? '0 : word + WW'(1);
        nxt_row   = last_word ? (last_row ? '0 : row + RW'(1)) : row;
    end

    // The ninth word arrives during COMPUTE, so it is taken straight off the bus.
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                cw[r][c] = win[r][c];
        cw[2][2] = mem_rd_data;
        for (int r = 0; r < 3; r++) begin
            alive_row[r][0] = (cw[r][0][31:28] != 4'd0);
            for (int p = 0; p < 8; p++)
                alive_row[r][p+1] = (cw[r][1][4*p +: 4] != 4'd0);
            alive_row[r][9] = (cw[r][2][3:0] != 4'd0);
        end
        next_data = '0;
        for (int p = 0; p < 8; p++)
            next_data[4*p +: 4] = cell_next(cw[1][1][4*p +: 4], alive_row[0][p +: 3],
                                            {alive_row[1][p+2], alive_row[1][p]},
                                            alive_row[2][p +: 3]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            word        <= '0;
            dr          <= 2'd0;
            dw          <= 2'd0;
            disp_bank   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            gen_count   <= 16'd0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= 9'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 9'd0;
            mem_wr_data <= 32'd0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= READ;
                        busy        <= 1'b1;
                        row         <= '0;
                        word        <= '0;
                        dr          <= 2'd0;
                        dw          <= 2'd0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= rd_address('0, '0, 2'd0, 2'd0);
                    end
                end
                READ: begin
                    if (dr != 2'd0 || dw != 2'd0)
                        win[prev_dr][prev_dw] <= mem_rd_data;
                    if (dr == 2'd2 && dw == 2'd2) begin
                        mem_rd_en <= 1'b0;
                        state     <= COMPUTE;
                    end else begin
                        dr          <= step_dr;
                        dw          <= step_dw;
                        mem_rd_addr <= rd_address(row, word, step_dr, step_dw);
                    end
                end
                COMPUTE: begin
                    mem_wr_data <= next_data;
                    mem_wr_addr <= 9'(int'(row) * COLS_WORDS + int'(word));
                    mem_wr_en   <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    mem_wr_en <= 1'b0;
                    row       <= nxt_row;
                    word      <= nxt_word;
                    if (last_word && last_row) begin
                        state <= SWAP;
                    end else begin
                        state       <= READ;
                        dr          <= 2'd0;
                        dw          <= 2'd0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= rd_address(nxt_row, nxt_word, 2'd0, 2'd0);
                    end
                end
                SWAP: begin
                    disp_bank <= ~disp_bank;
                    gen_count <= gen_count + 16'd1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gol_engine.sv
// Directed bench for gol_engine with a dual-port frame memory model.
module tb_gol_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        disp_bank, busy, done;
    logic [15:0] gen_count;
    logic        mem_rd_en, mem_rd_bank, mem_wr_en, mem_wr_bank;
    logic [8:0]  mem_rd_addr, mem_wr_addr;
    logic [31:0] mem_rd_data = 32'd0;
    logic [31:0] mem_wr_data;

    logic [31:0] mem [2][512];
    logic [31:0] exp_mem [512];
    logic [1:0]  tb_cmd = 2'd0;
    logic        tb_bank = 1'b0;
    logic [8:0]  tb_addr = 9'd0;
    logic [2:0]  tb_sel = 3'd0;
    logic [3:0]  tb_age = 4'd0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int strobe_err = 0;

    gol_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .disp_bank(disp_bank), .busy(busy), .done(done), .gen_count(gen_count),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // Frame memory: one-cycle read latency, plus bench load commands.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_bank][mem_rd_addr];
        if (tb_cmd == 2'd1) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 512; a++)
                    mem[b][a] <= 32'd0;
        end else if (tb_cmd == 2'd2) begin
            mem[tb_bank][tb_addr][{tb_sel, 2'b00} +: 4] <= tb_age;
        end
        if (mem_wr_en) mem[mem_wr_bank][mem_wr_addr] <= mem_wr_data;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (mem_wr_en && (mem_wr_bank === disp_bank)) strobe_err++;
        if (mem_wr_en && (reset || !busy)) strobe_err++;
        if (mem_rd_en && !busy) strobe_err++;
        if (mem_rd_bank !== disp_bank) strobe_err++;
        if (mem_wr_bank !== ~disp_bank) strobe_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_banks();
        @(negedge clk); tb_cmd = 2'd1;
        @(negedge clk); tb_cmd = 2'd0;
    endtask

    task automatic set_cell(input int bank, input int x, input int y, input int age);
        @(negedge clk);
        tb_bank = bank[0];
        tb_addr = 9'(y * 8 + x / 8);
        tb_sel  = 3'(x % 8);
        tb_age  = 4'(age);
        tb_cmd  = 2'd2;
        @(negedge clk); tb_cmd = 2'd0;
    endtask

    task automatic exp_clear();
        for (int a = 0; a < 512; a++) exp_mem[a] = 32'd0;
    endtask

    task automatic exp_set(input int x, input int y, input int age);
        exp_mem[y * 8 + x / 8][4 * (x % 8) +: 4] = 4'(age);
    endtask

    task automatic check_bank(input string tag, input int bank);
        int diffs = 0;
        int first = -1;
        for (int a = 0; a < 512; a++)
            if (mem[bank][a] !== exp_mem[a]) begin
                diffs++;
                if (first < 0) first = a;
            end
        vectors++;
        assert (diffs === 0) else begin
            miscompares++;
            $error("FAIL %s: %0d words differ, first addr %0d observed %h expected %h",
                   tag, diffs, first, mem[bank][first], exp_mem[first]);
        end
    endtask

    // Pulses start, optionally re-pulses it extra_at cycles in, waits for done.
    task automatic run_gen(input string tag, input int extra_at, output int busy_n, output int done_n);
        int n;
        bit seen;
        int b0, d0;
        b0 = busy_cyc;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 8000) begin
            start = (n == extra_at);
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        vectors++;
        assert (seen) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed no done after %0d cycles, expected done", tag, n);
        end
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        busy_n = busy_cyc - b0;
        done_n = done_cnt - d0;
    endtask

    initial begin
        int bn, dn;

        // Reset values
        #12;
        check("rst_disp_bank", {31'd0, disp_bank}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_gen_count", {16'd0, gen_count}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_rd_addr", {23'd0, mem_rd_addr}, 32'd0);
        check("rst_wr_addr", {23'd0, mem_wr_addr}, 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Blinker in the middle of a word row
        clear_banks();
        set_cell(0, 10, 20, 1); set_cell(0, 11, 20, 1); set_cell(0, 12, 20, 1);
        run_gen("blinker", -1, bn, dn);
        exp_clear(); exp_set(11, 19, 1); exp_set(11, 20, 2); exp_set(11, 21, 1);
        check_bank("blinker_bank1", 1);
        check("blinker_busy_cycles", bn, 5633);
        check("blinker_done_pulses", dn, 1);
        check("blinker_disp_bank", {31'd0, disp_bank}, 32'd1);
        check("blinker_gen_count", {16'd0, gen_count}, 32'd1);

        // Blinker straddling a word boundary, source now bank1
        clear_banks();
        set_cell(1, 7, 5, 1); set_cell(1, 8, 5, 1); set_cell(1, 9, 5, 1);
        run_gen("wordedge", -1, bn, dn);
        exp_clear(); exp_set(8, 4, 1); exp_set(8, 5, 2); exp_set(8, 6, 1);
        check_bank("wordedge_bank0", 0);
        check("wordedge_disp_bank", {31'd0, disp_bank}, 32'd0);
        check("wordedge_gen_count", {16'd0, gen_count}, 32'd2);

        // Toroidal corner block, with a second start 100 cycles in
        clear_banks();
        set_cell(0, 63, 63, 1); set_cell(0, 0, 63, 1); set_cell(0, 63, 0, 1); set_cell(0, 0, 0, 1);
        run_gen("torus", 100, bn, dn);
        exp_clear(); exp_set(63, 63, 2); exp_set(0, 63, 2); exp_set(63, 0, 2); exp_set(0, 0, 2);
        check_bank("torus_bank1", 1);
        check("busy_start_done_pulses", dn, 1);
        check("busy_start_busy_cycles", bn, 5633);
        check("busy_start_gen_count", {16'd0, gen_count}, 32'd3);
        check("torus_disp_bank", {31'd0, disp_bank}, 32'd1);
        run_gen("torus2", -1, bn, dn);
        exp_clear(); exp_set(63, 63, 3); exp_set(0, 63, 3); exp_set(63, 0, 3); exp_set(0, 0, 3);
        check_bank("torus2_bank0", 0);
        check("fresh_start_gen_count", {16'd0, gen_count}, 32'd4);
        check("fresh_start_done_pulses", dn, 1);

        // Reset in the middle of a generation
        clear_banks();
        set_cell(0, 10, 20, 1); set_cell(0, 11, 20, 1); set_cell(0, 12, 20, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3000) @(negedge clk);
        check("midgen_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midgen_rst_busy", {31'd0, busy}, 32'd0);
        check("midgen_rst_disp_bank", {31'd0, disp_bank}, 32'd0);
        check("midgen_rst_gen_count", {16'd0, gen_count}, 32'd0);
        check("midgen_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("midgen_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        @(negedge clk); start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        run_gen("after_rst", -1, bn, dn);
        exp_clear(); exp_set(11, 19, 1); exp_set(11, 20, 2); exp_set(11, 21, 1);
        check_bank("after_rst_bank1", 1);
        check("after_rst_gen_count", {16'd0, gen_count}, 32'd1);
        check("after_rst_disp_bank", {31'd0, disp_bank}, 32'd1);

        // Age saturation over two generations, from a fresh reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        clear_banks();
        set_cell(0, 30, 30, 15); set_cell(0, 31, 30, 15); set_cell(0, 30, 31, 15); set_cell(0, 31, 31, 15);
        exp_clear(); exp_set(30, 30, 15); exp_set(31, 30, 15); exp_set(30, 31, 15); exp_set(31, 31, 15);
        run_gen("sat1", -1, bn, dn);
        check_bank("sat1_bank1", 1);
        run_gen("sat2", -1, bn, dn);
        check_bank("sat2_bank0", 0);
        check("sat_disp_bank", {31'd0, disp_bank}, 32'd0);
        check("sat_gen_count", {16'd0, gen_count}, 32'd2);

        check("strobe_rules", strobe_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
